// File: rtl/proc_ctrl_if.sv
// Control/status bundle between the TinyRV1 pipeline controller (master) and its datapath (slave).
interface proc_ctrl_if;
    // imemresp_val is valid-only: the datapath has no backpressure, and a response is consumed
    // in the same cycle it is valid (the instruction register loads whenever c2d_reg_en_D is high).
    logic        imemresp_val;
    logic [31:0] d2c_inst;
    logic        d2c_eq;
    logic        c2d_imemreq_val;
    logic        c2d_reg_en_F;
    logic        c2d_reg_en_D;
    logic [1:0]  c2d_pc_sel_F;
    logic [1:0]  c2d_op1_byp_sel_D;
    logic [1:0]  c2d_op2_byp_sel_D;
    logic        c2d_op1_sel_D;
    logic [1:0]  c2d_op2_sel_D;
    logic [1:0]  c2d_alu_fn_X;
    logic        c2d_result_sel_X;
    logic        c2d_rf_wen_W;
    logic [4:0]  c2d_rf_waddr_W;
    logic        illegal_inst;
    logic [31:0] instret;

    modport master (
        input  imemresp_val, d2c_inst, d2c_eq,
        output c2d_imemreq_val, c2d_reg_en_F, c2d_reg_en_D, c2d_pc_sel_F,
               c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
               c2d_alu_fn_X, c2d_result_sel_X, c2d_rf_wen_W, c2d_rf_waddr_W,
               illegal_inst, instret
    );

    modport slave (
        output imemresp_val, d2c_inst, d2c_eq,
        input  c2d_imemreq_val, c2d_reg_en_F, c2d_reg_en_D, c2d_pc_sel_F,
               c2d_op1_byp_sel_D, c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D,
               c2d_alu_fn_X, c2d_result_sel_X, c2d_rf_wen_W, c2d_rf_waddr_W,
               illegal_inst, instret
    );
endinterface

// File: rtl/proc_ctrl.sv
// Five-stage TinyRV1 pipeline controller: decode, bypass, redirect/squash, writeback control
// and retired-instruction counting.
module proc_ctrl (
    input  logic        clk,
    input  logic        rst,
    proc_ctrl_if.master bus
);
    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rs1, rs2, rd;

    assign opcode = bus.d2c_inst[6:0];
    assign rd     = bus.d2c_inst[11:7];
    assign funct3 = bus.d2c_inst[14:12];
    assign rs1    = bus.d2c_inst[19:15];
    assign rs2    = bus.d2c_inst[24:20];
    assign funct7 = bus.d2c_inst[31:25];

    logic is_add, is_mul, is_addi, is_jal, is_jr, is_bne, legal;
    logic uses_rs1, uses_rs2, dec_rf_wen;

    assign is_add   = (opcode == OP_REG) && (funct3 == 3'd0) && (funct7 == 7'd0);
    assign is_mul   = (opcode == OP_REG) && (funct3 == 3'd0) && (funct7 == 7'd1);
    assign is_addi  = (opcode == OP_IMM) && (funct3 == 3'd0);
    assign is_jal   = (opcode == OP_JAL);
    assign is_jr    = (opcode == OP_JALR) && (funct3 == 3'd0);
    assign is_bne   = (opcode == OP_BR) && (funct3 == 3'd1);
    assign legal    = is_add | is_mul | is_addi | is_jal | is_jr | is_bne;
    assign uses_rs1 = is_add | is_mul | is_addi | is_jr | is_bne;
    assign uses_rs2 = is_add | is_mul | is_bne;
    assign dec_rf_wen = (is_add | is_mul | is_addi | is_jal | is_jr) && (rd != 5'd0);

    logic       val_D;
    logic       val_X, rf_wen_X, is_bne_X, result_sel_X;
    logic [4:0] rd_X;
    logic [1:0] alu_fn_X;
    logic       val_M, rf_wen_M;
    logic [4:0] rd_M;
    logic       val_W, rf_wen_W;
    logic [4:0] rd_W;
    logic [31:0] instret_q;

    logic bne_taken, jump_D, val_X_next, val_D_next;

    // A taken branch in X outranks everything younger, including a jump sitting in D.
    assign bne_taken  = val_X & is_bne_X & ~bus.d2c_eq;
    assign jump_D     = val_D & (is_jal | is_jr);
    assign val_X_next = val_D & legal & ~bne_taken;
    assign val_D_next = bus.imemresp_val & ~bne_taken & ~jump_D;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_D        <= 1'b0;
            val_X        <= 1'b0;
            rf_wen_X     <= 1'b0;
            is_bne_X     <= 1'b0;
            result_sel_X <= 1'b0;
            rd_X         <= 5'd0;
            alu_fn_X     <= 2'd0;
            val_M        <= 1'b0;
            rf_wen_M     <= 1'b0;
            rd_M         <= 5'd0;
            val_W        <= 1'b0;
            rf_wen_W     <= 1'b0;
            rd_W         <= 5'd0;
            instret_q    <= 32'd0;
        end else begin
            val_D        <= val_D_next;
            val_X        <= val_X_next;
            rf_wen_X     <= dec_rf_wen;
            is_bne_X     <= is_bne;
            rd_X         <= rd;
            alu_fn_X     <= (val_X_next && is_bne) ? 2'd1 : 2'd0;
            result_sel_X <= val_X_next & is_mul;
            val_M        <= val_X;
            rf_wen_M     <= rf_wen_X;
            rd_M         <= rd_X;
            val_W        <= val_M;
            rf_wen_W     <= rf_wen_M;
            rd_W         <= rd_M;
            if (val_W) instret_q <= instret_q + 32'd1;
        end
    end

    // Youngest producer wins; x0 and unused operands always read the register file.
    always_comb begin
        bus.c2d_op1_byp_sel_D = 2'd0;
        if (val_D && uses_rs1 && rs1 != 5'd0) begin
            if (val_X && rf_wen_X && rd_X == rs1)      bus.c2d_op1_byp_sel_D = 2'd1;
            else if (val_M && rf_wen_M && rd_M == rs1) bus.c2d_op1_byp_sel_D = 2'd2;
            else if (val_W && rf_wen_W && rd_W == rs1) bus.c2d_op1_byp_sel_D = 2'd3;
        end
    end

    always_comb begin
        bus.c2d_op2_byp_sel_D = 2'd0;
        if (val_D && uses_rs2 && rs2 != 5'd0) begin
            if (val_X && rf_wen_X && rd_X == rs2)      bus.c2d_op2_byp_sel_D = 2'd1;
            else if (val_M && rf_wen_M && rd_M == rs2) bus.c2d_op2_byp_sel_D = 2'd2;
            else if (val_W && rf_wen_W && rd_W == rs2) bus.c2d_op2_byp_sel_D = 2'd3;
        end
    end

    always_comb begin
        bus.c2d_pc_sel_F = 2'd0;
        if (bne_taken)   bus.c2d_pc_sel_F = 2'd3;
        else if (jump_D) bus.c2d_pc_sel_F = is_jal ? 2'd1 : 2'd2;
    end

    always_comb begin
        bus.c2d_op2_sel_D = 2'd0;
        if (val_D && is_addi)                bus.c2d_op2_sel_D = 2'd1;
        else if (val_D && (is_jal | is_jr))  bus.c2d_op2_sel_D = 2'd2;
    end

    assign bus.c2d_imemreq_val  = ~rst;
    assign bus.c2d_reg_en_F     = ~rst & (bne_taken | jump_D | bus.imemresp_val);
    assign bus.c2d_reg_en_D     = ~rst & bus.imemresp_val;
    assign bus.c2d_op1_sel_D    = val_D & (is_jal | is_jr);
    assign bus.c2d_alu_fn_X     = alu_fn_X;
    assign bus.c2d_result_sel_X = result_sel_X;
    assign bus.c2d_rf_wen_W     = val_W & rf_wen_W;
    assign bus.c2d_rf_waddr_W   = rd_W;
    assign bus.illegal_inst     = val_D & ~legal;
    assign bus.instret          = instret_q;
endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: emulates the datapath instruction register and predicts every
// control output from an instruction-timeline model of the TinyRV1 pipeline rules.
module tb_proc_ctrl;
    localparam int MAXC = 64;
    localparam int K_ILL = -1, K_ADD = 0, K_ADDI = 1, K_MUL = 2, K_JAL = 3, K_JR = 4, K_BNE = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    proc_ctrl_if bus();
    proc_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- program and model state ----------------
    bit          fval[MAXC];
    bit          eq[MAXC];
    logic [31:0] finst[MAXC];
    logic [31:0] ir[MAXC+1];
    bit          dval[MAXC+1];
    bit          live[MAXC], taken[MAXC], jmp[MAXC];
    logic [1:0]  e_pcsel[MAXC], e_byp1[MAXC], e_byp2[MAXC], e_op2sel[MAXC], e_alufn[MAXC];
    bit          e_regen_f[MAXC], e_ill[MAXC], e_op1sel[MAXC], e_ressel[MAXC], e_wen[MAXC];
    logic [4:0]  e_waddr[MAXC];
    logic [31:0] e_instret[MAXC];
    logic [4:0]  exp_q[$];

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] s2, input logic [4:0] s1, input logic [4:0] d);
        return {f7, s2, s1, 3'b000, d, 7'h33};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] d, input logic [4:0] s1, input logic [11:0] imm);
        return {imm, s1, 3'b000, d, 7'h13};
    endfunction
    function automatic logic [31:0] jal(input logic [4:0] d);
        return {20'h00800, d, 7'h6f};
    endfunction
    function automatic logic [31:0] jr(input logic [4:0] s1);
        return {12'd0, s1, 3'b000, 5'd0, 7'h67};
    endfunction
    function automatic logic [31:0] bne(input logic [4:0] s1, input logic [4:0] s2);
        return {7'd0, s2, s1, 3'b001, 5'b01000, 7'h63};
    endfunction

    function automatic int kind_of(input logic [31:0] i);
        if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'd0) return K_ADD;
        if (i[6:0] == 7'h33 && i[14:12] == 3'd0 && i[31:25] == 7'd1) return K_MUL;
        if (i[6:0] == 7'h13 && i[14:12] == 3'd0) return K_ADDI;
        if (i[6:0] == 7'h6f) return K_JAL;
        if (i[6:0] == 7'h67 && i[14:12] == 3'd0) return K_JR;
        if (i[6:0] == 7'h63 && i[14:12] == 3'd1) return K_BNE;
        return K_ILL;
    endfunction

    function automatic bit writes(input int k);
        return k == K_ADD || k == K_ADDI || k == K_MUL || k == K_JAL || k == K_JR;
    endfunction

    // Distance back in the instruction timeline to the youngest live writer of rs (1=X, 2=M, 3=W).
    function automatic logic [1:0] byp_model(input int c, input logic [4:0] rs, input bit used);
        logic [1:0] r;
        r = 2'd0;
        if (dval[c] && used && rs != 5'd0) begin
            for (int d = 3; d >= 1; d--) begin
                if (c - d >= 0) begin
                    if (live[c-d] && writes(kind_of(ir[c-d])) && ir[c-d][11:7] == rs) r = d[1:0];
                end
            end
        end
        return r;
    endfunction

    task automatic compute_model(input int n);
        int k, cnt;
        cnt = 0;
        dval[0] = 1'b0;
        ir[0] = 32'd0;
        for (int c = 0; c < n; c++) begin
            k = kind_of(ir[c]);
            taken[c] = 1'b0;
            if (c >= 1) taken[c] = live[c-1] && kind_of(ir[c-1]) == K_BNE && !eq[c];
            jmp[c]  = dval[c] && (k == K_JAL || k == K_JR);
            live[c] = dval[c] && k != K_ILL && !taken[c];
            dval[c+1] = fval[c] && !taken[c] && !jmp[c];
            ir[c+1]   = fval[c] ? finst[c] : ir[c];
            e_pcsel[c]   = taken[c] ? 2'd3 : (jmp[c] ? ((k == K_JAL) ? 2'd1 : 2'd2) : 2'd0);
            e_regen_f[c] = taken[c] || jmp[c] || fval[c];
            e_ill[c]     = dval[c] && k == K_ILL;
            e_byp1[c]    = byp_model(c, ir[c][19:15], k == K_ADD || k == K_MUL || k == K_ADDI || k == K_JR || k == K_BNE);
            e_byp2[c]    = byp_model(c, ir[c][24:20], k == K_ADD || k == K_MUL || k == K_BNE);
            e_op1sel[c]  = dval[c] && (k == K_JAL || k == K_JR);
            e_op2sel[c]  = !dval[c] ? 2'd0 : (k == K_ADDI) ? 2'd1 : (k == K_JAL || k == K_JR) ? 2'd2 : 2'd0;
            e_alufn[c]   = 2'd0;
            e_ressel[c]  = 1'b0;
            if (c >= 1 && live[c-1]) begin
                e_alufn[c]  = (kind_of(ir[c-1]) == K_BNE) ? 2'd1 : 2'd0;
                e_ressel[c] = kind_of(ir[c-1]) == K_MUL;
            end
            e_wen[c]   = 1'b0;
            e_waddr[c] = 5'd0;
            e_instret[c] = cnt;
            if (c >= 3 && live[c-3]) begin
                cnt++;
                if (writes(kind_of(ir[c-3])) && ir[c-3][11:7] != 5'd0) begin
                    e_wen[c]   = 1'b1;
                    e_waddr[c] = ir[c-3][11:7];
                end
            end
        end
    endtask

    task automatic clear_prog();
        for (int c = 0; c < MAXC; c++) begin
            fval[c]  = 1'b0;
            eq[c]    = 1'b1;
            finst[c] = addi(5'd0, 5'd0, 12'd0);
        end
    endtask

    // ---------------- clock/reset and driver tasks ----------------
    task automatic apply_reset();
        rst = 1'b1;
        bus.imemresp_val = 1'b0;
        bus.d2c_inst = 32'd0;
        bus.d2c_eq = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive_cycle(input int c);
        bus.imemresp_val = fval[c];
        bus.d2c_inst     = ir[c];
        bus.d2c_eq       = eq[c];
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [53:0] got;
        rst = 1'b1;
        bus.imemresp_val = 1'b1;
        bus.d2c_inst = jal(5'd1);
        bus.d2c_eq = 1'b0;
        @(posedge clk);
        #3;
        got = {bus.c2d_imemreq_val, bus.c2d_reg_en_F, bus.c2d_reg_en_D, bus.c2d_pc_sel_F,
               bus.c2d_op1_byp_sel_D, bus.c2d_op2_byp_sel_D, bus.c2d_op1_sel_D, bus.c2d_op2_sel_D,
               bus.c2d_alu_fn_X, bus.c2d_result_sel_X, bus.c2d_rf_wen_W, bus.c2d_rf_waddr_W,
               bus.illegal_inst, bus.instret};
        n_tests++;
        if (got !== 54'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", got);
        end
        apply_reset();
        bus.imemresp_val = 1'b0;
        #2;
        n_tests++;
        if (bus.c2d_imemreq_val !== 1'b1 || bus.instret !== 32'd0 || bus.c2d_rf_wen_W !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: imemreq=%b instret=%0d wen=%b expected 1/0/0",
                     bus.c2d_imemreq_val, bus.instret, bus.c2d_rf_wen_W);
        end
    endtask

    task automatic test_bypass_x();
        clear_prog();
        finst[0] = addi(5'd1, 5'd0, 12'd5); fval[0] = 1'b1;
        finst[1] = r_type(7'd0, 5'd1, 5'd1, 5'd2); fval[1] = 1'b1;
        compute_model(12);
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            drive_cycle(c);
            #2;
            if (c == 2) begin
                n_tests++;
                if (bus.c2d_op1_byp_sel_D !== 2'd1 || bus.c2d_op2_byp_sel_D !== 2'd1) begin
                    n_fail++;
                    $display("FAIL byp_x: got %0d/%0d expected 1/1", bus.c2d_op1_byp_sel_D, bus.c2d_op2_byp_sel_D);
                end
            end
            if (c == 4 || c == 5) begin
                n_tests++;
                if (bus.c2d_rf_wen_W !== 1'b1 || bus.c2d_rf_waddr_W !== 5'(c - 3)) begin
                    n_fail++;
                    $display("FAIL byp_x_wb c=%0d: got wen=%b addr=%0d expected 1/%0d", c, bus.c2d_rf_wen_W, bus.c2d_rf_waddr_W, c - 3);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (bus.instret !== 32'd2) begin
            n_fail++;
            $display("FAIL byp_x_instret: got %0d expected 2", bus.instret);
        end
    endtask

    task automatic test_bypass_w();
        logic [4:0] dst;
        for (int v = 0; v < 2; v++) begin
            dst = (v == 0) ? 5'd3 : 5'd0;
            clear_prog();
            for (int i = 0; i < 4; i++) fval[i] = 1'b1;
            finst[0] = addi(dst, 5'd0, 12'd7);
            finst[3] = r_type(7'd0, 5'd0, dst, 5'd4);
            compute_model(12);
            apply_reset();
            for (int c = 0; c < 12; c++) begin
                drive_cycle(c);
                #2;
                if (c == 4) begin
                    n_tests++;
                    if (bus.c2d_op1_byp_sel_D !== ((v == 0) ? 2'd3 : 2'd0) || bus.c2d_op2_byp_sel_D !== 2'd0
                        || bus.c2d_rf_wen_W !== (v == 0)) begin
                        n_fail++;
                        $display("FAIL byp_w v=%0d: got byp=%0d/%0d wen=%b", v, bus.c2d_op1_byp_sel_D,
                                 bus.c2d_op2_byp_sel_D, bus.c2d_rf_wen_W);
                    end
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_branch_over_jump();
        clear_prog();
        for (int c = 0; c < MAXC; c++) eq[c] = 1'b0;
        for (int i = 0; i < 4; i++) fval[i] = 1'b1;
        finst[0] = bne(5'd1, 5'd2);
        finst[1] = jal(5'd1);
        finst[2] = addi(5'd5, 5'd0, 12'd1);
        finst[3] = addi(5'd6, 5'd0, 12'd1);
        compute_model(14);
        apply_reset();
        for (int c = 0; c < 14; c++) begin
            drive_cycle(c);
            #2;
            if (c == 2) begin
                n_tests++;
                if (bus.c2d_pc_sel_F !== 2'd3 || bus.c2d_reg_en_F !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bne_redirect: got pc_sel=%0d en_F=%b expected 3/1", bus.c2d_pc_sel_F, bus.c2d_reg_en_F);
                end
            end
            n_tests++;
            if (bus.c2d_rf_wen_W === 1'b1 && bus.c2d_rf_waddr_W !== 5'd6) begin
                n_fail++;
                $display("FAIL bne_squash c=%0d: got write to x%0d expected only x6", c, bus.c2d_rf_waddr_W);
            end
            next_cycle();
        end
        n_tests++;
        if (bus.instret !== 32'd2) begin
            n_fail++;
            $display("FAIL bne_instret: got %0d expected 2", bus.instret);
        end
    endtask

    task automatic test_jal();
        clear_prog();
        for (int i = 0; i < 3; i++) fval[i] = 1'b1;
        finst[0] = jal(5'd1);
        finst[1] = addi(5'd7, 5'd0, 12'd1);
        finst[2] = addi(5'd8, 5'd0, 12'd1);
        compute_model(12);
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            drive_cycle(c);
            #2;
            if (c == 1 || c == 2) begin
                n_tests++;
                if (bus.c2d_pc_sel_F !== ((c == 1) ? 2'd1 : 2'd0) || bus.c2d_op1_sel_D !== (c == 1)) begin
                    n_fail++;
                    $display("FAIL jal_pc_sel c=%0d: got pc_sel=%0d op1_sel=%b", c, bus.c2d_pc_sel_F, bus.c2d_op1_sel_D);
                end
            end
            if (c >= 4 && c <= 6) begin
                n_tests++;
                if (bus.c2d_rf_wen_W !== (c != 5) || (c == 4 && bus.c2d_rf_waddr_W !== 5'd1)
                    || (c == 6 && bus.c2d_rf_waddr_W !== 5'd8)) begin
                    n_fail++;
                    $display("FAIL jal_wb c=%0d: got wen=%b addr=%0d", c, bus.c2d_rf_wen_W, bus.c2d_rf_waddr_W);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_imem_wait();
        clear_prog();
        for (int i = 0; i < 8; i++) begin
            fval[i]  = !(i >= 3 && i <= 5);
            finst[i] = addi(5'(i + 1), 5'd0, 12'd3);
        end
        compute_model(16);
        apply_reset();
        for (int c = 0; c < 16; c++) begin
            drive_cycle(c);
            #2;
            if (c >= 2 && c <= 6) begin
                n_tests++;
                if (bus.c2d_reg_en_F !== !(c >= 3 && c <= 5)) begin
                    n_fail++;
                    $display("FAIL imem_wait_en c=%0d: got %b", c, bus.c2d_reg_en_F);
                end
            end
            if (c >= 6 && c <= 10) begin
                n_tests++;
                if (bus.c2d_rf_wen_W !== !(c >= 7 && c <= 9)) begin
                    n_fail++;
                    $display("FAIL imem_wait_bubble c=%0d: got wen=%b", c, bus.c2d_rf_wen_W);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (bus.instret !== 32'd5) begin
            n_fail++;
            $display("FAIL imem_wait_instret: got %0d expected 5", bus.instret);
        end
    endtask

    task automatic test_illegal();
        clear_prog();
        fval[0] = 1'b1; finst[0] = 32'h0000007f;
        fval[1] = 1'b1; finst[1] = addi(5'd9, 5'd0, 12'd1);
        compute_model(10);
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c);
            #2;
            if (c >= 1 && c <= 2) begin
                n_tests++;
                if (bus.illegal_inst !== (c == 1)) begin
                    n_fail++;
                    $display("FAIL illegal_pulse c=%0d: got %b", c, bus.illegal_inst);
                end
            end
            if (c == 4) begin
                n_tests++;
                if (bus.c2d_rf_wen_W !== 1'b0) begin
                    n_fail++;
                    $display("FAIL illegal_nowb: got wen=%b expected 0", bus.c2d_rf_wen_W);
                end
            end
            next_cycle();
        end
        n_tests++;
        if (bus.instret !== 32'd1) begin
            n_fail++;
            $display("FAIL illegal_instret: got %0d expected 1", bus.instret);
        end
    endtask

    task automatic test_reset_mid();
        clear_prog();
        for (int i = 0; i < 20; i++) begin
            fval[i]  = 1'b1;
            finst[i] = addi(5'(1 + (i % 7)), 5'd0, 12'd1);
        end
        compute_model(20);
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            drive_cycle(c);
            next_cycle();
        end
        drive_cycle(10);
        #2;
        n_tests++;
        if (bus.instret !== e_instret[10] || bus.c2d_rf_wen_W !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_before: got instret=%0d wen=%b expected %0d/1", bus.instret, bus.c2d_rf_wen_W, e_instret[10]);
        end
        rst = 1'b1;
        #1;
        n_tests++;
        if (bus.instret !== 32'd0 || bus.c2d_rf_wen_W !== 1'b0 || bus.c2d_reg_en_F !== 1'b0
            || bus.c2d_imemreq_val !== 1'b0 || bus.c2d_op1_byp_sel_D !== 2'd0) begin
            n_fail++;
            $display("FAIL mid_reset: got instret=%0d wen=%b en_F=%b req=%b byp=%0d expected all 0",
                     bus.instret, bus.c2d_rf_wen_W, bus.c2d_reg_en_F, bus.c2d_imemreq_val, bus.c2d_op1_byp_sel_D);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] t;
        case ($urandom_range(0, 7))
            0: t = r_type(7'd0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            1: t = addi(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 12'($urandom_range(0, 100)));
            2: t = r_type(7'd1, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            3: t = jal(5'($urandom_range(0, 3)));
            4: t = jr(5'($urandom_range(0, 3)));
            5: t = bne(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            6: t = addi(5'd0, 5'd0, 12'd0);
            default: begin
                t = $urandom;
                t[6:0] = 7'h7f;
            end
        endcase
        return t;
    endfunction

    task automatic test_random();
        localparam int N = 48;
        logic [53:0] got, expv;
        logic [4:0]  wa;
        for (int round = 0; round < 4; round++) begin
            clear_prog();
            for (int c = 0; c < N; c++) begin
                fval[c]  = (c < N - 6) && ($urandom_range(0, 9) < 8);
                finst[c] = rand_inst();
                eq[c]    = 1'($urandom_range(0, 1));
            end
            compute_model(N);
            exp_q.delete();
            for (int c = 0; c < N; c++) if (e_wen[c]) exp_q.push_back(e_waddr[c]);
            apply_reset();
            for (int c = 0; c < N; c++) begin
                drive_cycle(c);
                #2;
                wa = e_wen[c] ? bus.c2d_rf_waddr_W : 5'd0;
                got = {bus.c2d_imemreq_val, bus.c2d_reg_en_F, bus.c2d_reg_en_D, bus.c2d_pc_sel_F,
                       bus.c2d_op1_byp_sel_D, bus.c2d_op2_byp_sel_D, bus.c2d_op1_sel_D, bus.c2d_op2_sel_D,
                       bus.c2d_alu_fn_X, bus.c2d_result_sel_X, bus.c2d_rf_wen_W, wa,
                       bus.illegal_inst, bus.instret};
                expv = {1'b1, e_regen_f[c], fval[c], e_pcsel[c], e_byp1[c], e_byp2[c], e_op1sel[c],
                        e_op2sel[c], e_alufn[c], e_ressel[c], e_wen[c], e_waddr[c], e_ill[c], e_instret[c]};
                n_tests++;
                if (got !== expv) begin
                    n_fail++;
                    $display("FAIL random r=%0d c=%0d inst=%h: got %h expected %h", round, c, ir[c], got, expv);
                end
                if (bus.c2d_rf_wen_W === 1'b1) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL random_wb r=%0d c=%0d: got write x%0d expected none", round, c, bus.c2d_rf_waddr_W);
                    end else if (bus.c2d_rf_waddr_W !== exp_q.pop_front()) begin
                        n_fail++;
                        $display("FAIL random_wb r=%0d c=%0d: got write x%0d out of order", round, c, bus.c2d_rf_waddr_W);
                    end
                end
                next_cycle();
            end
            n_tests++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL random_wb_drain r=%0d: got %0d writes missing expected 0", round, exp_q.size());
            end
        end
    endtask

    initial begin
        bus.imemresp_val = 1'b0;
        bus.d2c_inst = 32'd0;
        bus.d2c_eq = 1'b0;
        test_reset();
        test_bypass_x();
        test_bypass_w();
        test_branch_over_jump();
        test_jal();
        test_imem_wait();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Pipeline control unit for the five-stage TinyRV1 core (F, D, X, M, W); drives every c2d_* signal of the processor datapath and consumes its d2c_* status.
- Tracks per-stage valid bits and decoded instruction state.
- Generates bypass selects, stalls, squashes, PC redirects and register-file writeback control.
- Counts retired instructions.

Parameters:
- None. The ISA subset is fixed: ADD, ADDI, MUL, JAL, JR, BNE. Any other encoding is an illegal instruction.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
imemresp_val  in  1  imemresp_data holds a valid instruction this cycle
d2c_inst  in  32  instruction register contents (D stage)
d2c_eq  in  1  ALU equality result in X (1 = operands equal)
c2d_imemreq_val  out  1  fetch request valid
c2d_reg_en_F  out  1  PC register enable
c2d_reg_en_D  out  1  F/D instruction register enable
c2d_pc_sel_F  out  2  0 = pc+4, 1 = JAL target, 2 = JR target (rs1), 3 = BNE target
c2d_op1_byp_sel_D  out  2  0 = regfile, 1 = X, 2 = M, 3 = W
c2d_op2_byp_sel_D  out  2  same encoding as op1
c2d_op1_sel_D  out  1  0 = bypassed rs1, 1 = PC (JAL link computation)
c2d_op2_sel_D  out  2  0 = bypassed rs2, 1 = I-immediate, 2 = constant 4
c2d_alu_fn_X  out  2  0 = add, 1 = eq compare, 2 = pass op1
c2d_result_sel_X  out  1  0 = ALU, 1 = multiplier
c2d_rf_wen_W  out  1  register-file write enable
c2d_rf_waddr_W  out  5  register-file write address
illegal_inst  out  1  pulse: a valid illegal instruction was dropped in D
instret  out  32  retired-instruction count

Behaviour:
- Reset (async, rst=1):
  - val_D/X/M/W = 0, c2d_imemreq_val = 0, instret = 0, all other outputs 0.
  - First cycle after deassertion: c2d_imemreq_val = 1, fetch starts at PC reset value.
- Per-stage state registers:
  - X, M, W each hold: val, rf_wen, rd, is_bne.
  - D holds only val_D. Instruction fields decode combinationally from d2c_inst.
  - rd = x0 forces rf_wen = 0.
- Bypass selection (D, combinational, per operand):
  - Source register is nonzero, the instruction uses it, and some later stage has val & rf_wen & rd == rs.
  - Youngest match wins: X > M > W. No match selects regfile (0).
- Every result is ready at end of X, so there is no RAW stall.
- Imem wait: imemresp_val = 0 with no redirect gives:
  - c2d_reg_en_F = 0; val_D next = 0 (bubble).
  - The instruction already in D still advances.
- Redirects:
  - BNE taken: val_X & is_bne & !d2c_eq.
    - pc_sel = 3, reg_en_F = 1.
    - Squash D (val_X next = 0) and F (val_D next = 0): 2 bubbles.
  - JAL/JR in valid D: pc_sel = 1 or 2, reg_en_F = 1, val_D next = 0 (1 bubble).
  - JAL/JR instructions proceed to X and write the link register (pc+4) to rd.
  - Simultaneous events: taken BNE in X overrides a jump in D, and the jump is squashed. Any redirect overrides an imem wait, so the PC still updates.
- Otherwise: pc_sel = 0, reg_en_F = reg_en_D = imemresp_val.
- Illegal instruction in valid D:
  - Converted to a bubble (val_X next = 0).
  - illegal_inst = 1 for that cycle only.
- W stage:
  - c2d_rf_wen_W = val_W & rf_wen_W; c2d_rf_waddr_W = rd_W.
  - instret increments by 1 every cycle val_W = 1. It wraps at 2^32 to 0.
- alu_fn / result_sel / op sels:
  - Decoded in D; the X-stage controls are registered into X.
  - MUL selects result_sel = 1.
  - BNE uses alu_fn = 1.
- Reset asserted mid-operation: all in-flight instructions are discarded immediately; no writeback occurs after rst rises.

Test Plan:
- Reset released; imem always valid; straight-line ADDI x1,x0,5 then ADD x2,x1,x1 -> op1/op2_byp_sel_D = 1 for the ADD; rf_wen_W for rd = 1 and then rd = 2 on consecutive cycles; instret = 2.
- ADDI x3; NOP; NOP; ADD x4,x3,x0 -> op1_byp_sel = 3 (W). Same test with write to x0 -> byp_sel stays 0 and rf_wen_W = 0.
- BNE with d2c_eq = 0 in X while JAL is in D -> pc_sel = 3; the JAL never reaches W; exactly 2 bubbles; instret excludes the squashed instructions.
- JAL x1 in D -> pc_sel = 1 for one cycle; the following fetch is squashed; rf_wen_W with waddr = 1 is seen 3 cycles later.
- imemresp_val low for 3 cycles mid-stream -> reg_en_F = 0 for 3 cycles; 3 bubbles in W; instret unaffected for those slots.
- Illegal opcode 0x0000007F in D -> illegal_inst pulses for 1 cycle, no writeback. rst asserted mid-stream -> all outputs 0 and instret = 0 in the same cycle.
